dino_motion_ctrl: RTL and testbench

DINO_MOTION_CTRL -- requirements
Module: dino_motion_ctrl

---
 rtl/dino_pkg.sv | 23 ++
 rtl/btn_edge_latch.sv | 31 +++
 rtl/dino_motion_ctrl.sv | 144 ++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared codes and state encoding for the dino motion controller.
package dino_pkg;

  localparam logic [1:0] GAME_INIT  = 2'd0;
  localparam logic [1:0] GAME_START = 2'd1;
  localparam logic [1:0] GAME_END   = 2'd2;
  localparam logic [1:0] GAME_RESET = 2'd3;

  localparam logic STAND = 1'b1;
  localparam logic SIT   = 1'b0;

  localparam int GROUND = 298;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DUCK,
    ST_ASCEND,
    ST_DESCEND,
    ST_DEAD
  } dino_state_e;

endpackage

// File: rtl/btn_edge_latch.sv
// Latches a rising edge of a button level until a frame tick consumes it,
// so a press shorter than one frame is not lost.
module btn_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clear,
  input  logic consume,
  output logic req
);

  logic btn_q;
  logic rise;

  assign rise = btn & ~btn_q;

  // Clear dominates a coincident edge; an edge on the consuming tick survives
  // for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      req   <= 1'b0;
    end else begin
      btn_q <= btn;
      if (clear)        req <= 1'b0;
      else if (rise)    req <= 1'b1;
      else if (consume) req <= 1'b0;
    end
  end

endmodule

// File: rtl/dino_motion_ctrl.sv
// Per-frame jump/duck motion controller producing the dino's vertical position.
//   state      | meaning
//   IDLE       | parked on the ground, waiting for the game to start
//   RUN        | on the ground, standing
//   DUCK       | on the ground, crouched
//   ASCEND     | rising; velocity decays by gravity each frame
//   DESCEND    | falling; fall speed grows up to the terminal value
//   DEAD       | game over, position frozen
module dino_motion_ctrl #(
  parameter int GROUND    = dino_pkg::GROUND,
  parameter int JUMP_V0   = 14,
  parameter int V_CUT     = 6,
  parameter int GRAV      = 1,
  parameter int FAST_GRAV = 3,
  parameter int MAX_FALL  = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       jump_btn,
  input  logic       duck_btn,
  input  logic [1:0] game_state,
  output logic [9:0] pos,
  output logic       dino_behavior,
  output logic       airborne,
  output logic       land
);

  import dino_pkg::*;

  localparam logic [9:0]  GROUND_P   = 10'(GROUND);
  localparam logic [10:0] GROUND_W   = 11'(GROUND);
  localparam logic [4:0]  V0_P       = 5'(JUMP_V0);
  localparam logic [4:0]  VCUT_P     = 5'(V_CUT);
  localparam logic [4:0]  GRAV_P     = 5'(GRAV);
  localparam logic [4:0]  FGRAV_P    = 5'(FAST_GRAV);
  localparam logic [5:0]  MAXFALL_P  = 6'(MAX_FALL);

  dino_state_e state, state_n;
  logic [9:0]  pos_n;
  logic [4:0]  vel, vel_n;
  logic [4:0]  fall, fall_n;
  logic        land_n;

  logic        jump_req;
  logic        force_idle;
  logic [4:0]  g;
  logic [4:0]  veff;
  logic [4:0]  vel_dec;
  logic [5:0]  fall_sum;
  logic [4:0]  nfall;
  logic [10:0] land_sum;

  assign force_idle = (game_state == GAME_INIT) || (game_state == GAME_RESET);

  btn_edge_latch u_jump_latch (
    .clk     (clk),
    .rst     (rst),
    .btn     (jump_btn),
    .clear   (force_idle),
    .consume (frame_tick),
    .req     (jump_req)
  );

  always_comb begin
    g        = duck_btn ? FGRAV_P : GRAV_P;
    veff     = (!jump_btn && (vel > VCUT_P)) ? VCUT_P : vel;
    vel_dec  = (veff > g) ? (veff - g) : 5'd0;
    fall_sum = {1'b0, fall} + {1'b0, g};
    nfall    = (fall_sum > MAXFALL_P) ? MAXFALL_P[4:0] : fall_sum[4:0];
    land_sum = {1'b0, pos} + {6'd0, nfall};
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    vel_n   = vel;
    fall_n  = fall;
    land_n  = 1'b0;

    if (force_idle) begin
      state_n = ST_IDLE;
      pos_n   = GROUND_P;
      vel_n   = 5'd0;
      fall_n  = 5'd0;
    end else if (game_state == GAME_END) begin
      state_n = ST_DEAD;
    end else if (frame_tick) begin
      case (state)
        ST_IDLE: state_n = ST_RUN;
        ST_RUN, ST_DUCK: begin
          if (jump_req) begin
            state_n = ST_ASCEND;
            vel_n   = V0_P;
          end else begin
            state_n = duck_btn ? ST_DUCK : ST_RUN;
          end
        end
        ST_ASCEND: begin
          // Clamp at the top of the screen so a large jump cannot wrap pos.
          pos_n = ({5'd0, veff} > pos) ? 10'd0 : (pos - {5'd0, veff});
          vel_n = vel_dec;
          if (vel_dec == 5'd0) begin
            state_n = ST_DESCEND;
            fall_n  = 5'd0;
          end
        end
        ST_DESCEND: begin
          if (land_sum >= GROUND_W) begin
            pos_n   = GROUND_P;
            fall_n  = 5'd0;
            land_n  = 1'b1;
            state_n = duck_btn ? ST_DUCK : ST_RUN;
          end else begin
            pos_n  = land_sum[9:0];
            fall_n = nfall;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pos           <= GROUND_P;
      vel           <= 5'd0;
      fall          <= 5'd0;
      dino_behavior <= STAND;
      airborne      <= 1'b0;
      land          <= 1'b0;
    end else begin
      state         <= state_n;
      pos           <= pos_n;
      vel           <= vel_n;
      fall          <= fall_n;
      dino_behavior <= (state_n == ST_DUCK) ? SIT : STAND;
      airborne      <= (state_n == ST_ASCEND) || (state_n == ST_DESCEND);
      land          <= land_n;
    end
  end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed bench for dino_motion_ctrl: a vector table for ground/duck/short-hop
// behaviour plus hand-written jump, game-over and reset sequences.
module tb_dino_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       jump_btn;
  logic       duck_btn;
  logic [1:0] game_state;
  logic [9:0] pos;
  logic       dino_behavior;
  logic       airborne;
  logic       land;

  int n_chk  = 0;
  int n_fail = 0;

  dino_motion_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .jump_btn      (jump_btn),
    .duck_btn      (duck_btn),
    .game_state    (game_state),
    .pos           (pos),
    .dino_behavior (dino_behavior),
    .airborne      (airborne),
    .land          (land)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       jump;
    logic       duck;
    logic [1:0] gs;
    logic       tick;
    int         exp_pos;
    logic       exp_beh;
    logic       exp_air;
    logic       exp_land;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One idle clock, then a single-cycle frame tick; returns on the negedge
  // after the tick has been taken.
  task automatic tick_once();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_p;

    vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 298, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'd1, 1'b0, 298, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 1'b1, 298, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd1, 1'b0, 298, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 1'b1, 298, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 298, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'd1, 1'b1, 298, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'd1, 1'b0, 298, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 298, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 1'b1, 298, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 1'b1, 292, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 292, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 2'd1, 1'b1, 289, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd1, 1'b1, 292, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 2'd1, 1'b1, 298, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 2'd1, 1'b0, 298, 1'b0, 1'b0, 1'b0};

    rst        = 1'b1;
    frame_tick = 1'b0;
    jump_btn   = 1'b0;
    duck_btn   = 1'b0;
    game_state = 2'd0;
    repeat (3) @(negedge clk);
    chk("reset_pos", int'(pos), 298);
    chk("reset_beh", int'(dino_behavior), 1);
    chk("reset_air", int'(airborne), 0);
    chk("reset_land", int'(land), 0);
    rst = 1'b0;

    // Table: idle->run, duck on ground, short hop with duck held, land in DUCK.
    for (int i = 0; i < 16; i++) begin
      jump_btn   = vecs[i].jump;
      duck_btn   = vecs[i].duck;
      game_state = vecs[i].gs;
      frame_tick = vecs[i].tick;
      @(negedge clk);
      frame_tick = 1'b0;
      chk($sformatf("vec%0d_pos", i), int'(pos), vecs[i].exp_pos);
      chk($sformatf("vec%0d_beh", i), int'(dino_behavior), int'(vecs[i].exp_beh));
      chk($sformatf("vec%0d_air", i), int'(airborne), int'(vecs[i].exp_air));
      chk($sformatf("vec%0d_land", i), int'(land), int'(vecs[i].exp_land));
    end

    // Full jump with the button held: apex 193 at tick 14, touchdown at 28.
    duck_btn = 1'b0;
    tick_once();
    chk("run_after_duck_beh", int'(dino_behavior), 1);
    jump_btn = 1'b1;
    tick_once();
    chk("full_t0_air", int'(airborne), 1);
    exp_p = 298;
    for (int t = 1; t <= 28; t++) begin
      tick_once();
      if (t <= 14) exp_p -= 15 - t;
      else         exp_p += t - 14;
      chk($sformatf("full_t%0d_pos", t), int'(pos), exp_p);
      chk($sformatf("full_t%0d_air", t), int'(airborne), (t <= 27) ? 1 : 0);
      if (t >= 27) chk($sformatf("full_t%0d_land", t), int'(land), (t == 28) ? 1 : 0);
      if (t == 14) chk("full_apex", int'(pos), 193);
    end
    @(negedge clk);
    chk("full_land_one_pulse", int'(land), 0);
    jump_btn = 1'b0;

    // One-clock press between ticks: ascent capped at 6 from tick 1.
    @(negedge clk);
    jump_btn = 1'b1;
    @(negedge clk);
    jump_btn = 1'b0;
    tick_once();
    chk("short_t0_air", int'(airborne), 1);
    exp_p = 298;
    for (int t = 1; t <= 6; t++) begin
      tick_once();
      exp_p -= 7 - t;
      chk($sformatf("short_t%0d_pos", t), int'(pos), exp_p);
    end
    chk("short_apex", int'(pos), 277);
    for (int n = 0; n < 40 && airborne; n++) tick_once();
    chk("short_landed_air", int'(airborne), 0);
    chk("short_landed_pos", int'(pos), 298);

    // Game over at the apex, with END and a tick arriving together.
    jump_btn = 1'b1;
    tick_once();
    for (int t = 1; t <= 14; t++) tick_once();
    chk("dead_apex_pos", int'(pos), 193);
    @(negedge clk);
    game_state = 2'd2;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("dead_end_tick_pos", int'(pos), 193);
    chk("dead_air", int'(airborne), 0);
    for (int k = 0; k < 10; k++) begin
      tick_once();
      chk($sformatf("dead_hold%0d_pos", k), int'(pos), 193);
    end
    game_state = 2'd3;
    @(negedge clk);
    chk("game_reset_pos", int'(pos), 298);
    chk("game_reset_air", int'(airborne), 0);
    game_state = 2'd1;
    tick_once();
    chk("restart_pos", int'(pos), 298);
    chk("restart_air", int'(airborne), 0);
    jump_btn = 1'b0;

    // Reset mid-jump, then a press during INIT must not leak into START.
    @(negedge clk);
    jump_btn = 1'b1;
    tick_once();
    for (int t = 1; t <= 5; t++) tick_once();
    chk("midjump_t5_pos", int'(pos), 238);
    rst      = 1'b1;
    jump_btn = 1'b0;
    @(negedge clk);
    chk("rst_mid_pos", int'(pos), 298);
    chk("rst_mid_air", int'(airborne), 0);
    chk("rst_mid_land", int'(land), 0);
    chk("rst_mid_beh", int'(dino_behavior), 1);
    rst        = 1'b0;
    game_state = 2'd0;
    @(negedge clk);
    jump_btn = 1'b1;
    @(negedge clk);
    jump_btn = 1'b0;
    @(negedge clk);
    game_state = 2'd1;
    tick_once();
    tick_once();
    chk("stale_jump_air1", int'(airborne), 0);
    tick_once();
    chk("stale_jump_air2", int'(airborne), 0);
    chk("stale_jump_pos", int'(pos), 298);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
